// File: rtl/scope_trigger_ctrl_pkg.sv
// Shared encodings and default sizing for the oscilloscope trigger/capture controller.
package scope_trigger_ctrl_pkg;

    localparam int DATA_W_DEF       = 14;
    localparam int DEPTH_DEF        = 800;
    localparam int ADDR_W_DEF       = 10;
    localparam int AUTO_TIMEOUT_DEF = 2000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // Mode code 3 falls through every test below and so behaves as normal.
    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;

endpackage

// File: rtl/trig_edge_detect.sv
// Level-crossing detector: remembers the previous qualified sample and flags a
// rising or falling crossing of the threshold on the current one.
module trig_edge_detect
    import scope_trigger_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_level,
    input  logic              i_slope,
    output logic              o_hit
);

    logic [DATA_W-1:0] r_prev;
    logic              r_prev_ok;
    logic              w_rise;
    logic              w_fall;

    // r_prev_ok drops outside ARMED so the first sample after entry only primes r_prev.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev    <= '0;
            r_prev_ok <= 1'b0;
        end else if (i_clear) begin
            r_prev_ok <= 1'b0;
        end else if (i_en) begin
            r_prev    <= i_data;
            r_prev_ok <= 1'b1;
        end
    end

    assign w_rise = (r_prev < i_level) && (i_data >= i_level);
    assign w_fall = (r_prev > i_level) && (i_data <= i_level);
    assign o_hit  = i_en && r_prev_ok && (i_slope ? w_fall : w_rise);

endmodule

// File: rtl/scope_trigger_ctrl.sv
// Trigger/capture sequencer: waits for a threshold crossing (or an auto-mode
// timeout), streams one frame into the sample buffer, then holds it for display.
module scope_trigger_ctrl
    import scope_trigger_ctrl_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int AUTO_TIMEOUT = AUTO_TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic              frame_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              buf_ready,
    output logic              triggered,
    output logic [1:0]        state
);

    localparam int                TO_W      = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_buf_ready;
    logic              r_triggered;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_last;
    logic [TO_W-1:0]   r_to;
    logic              w_sample;
    logic              w_hit;
    logic              w_timeout;

    assign w_sample  = data_valid && (r_state == ST_ARMED);
    assign w_timeout = w_sample && (mode == MODE_AUTO) && (r_to == TO_LAST);

    trig_edge_detect #(.DATA_W(DATA_W)) u_edge (
        .clock   (clock),
        .reset   (reset),
        .i_clear (r_state != ST_ARMED),
        .i_en    (w_sample),
        .i_data  (data),
        .i_level (trig_level),
        .i_slope (trig_slope),
        .o_hit   (w_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_buf_ready <= 1'b0;
            r_triggered <= 1'b0;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_to        <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mode != MODE_SINGLE || arm) begin
                        r_state <= ST_ARMED;
                        r_to    <= '0;
                    end
                end
                ST_ARMED: begin
                    if (w_sample) begin
                        if (w_hit || w_timeout) begin
                            r_state     <= ST_CAPTURE;
                            r_wr_en     <= 1'b1;
                            r_wr_addr   <= '0;
                            r_wr_data   <= data;
                            r_triggered <= w_hit;
                            r_cnt       <= ADDR_W'(1);
                            r_last      <= (DEPTH == 1);
                        end else if (mode == MODE_AUTO) begin
                            r_to <= r_to + TO_W'(1);
                        end
                    end
                end
                // The final write stays visible for one CAPTURE cycle before HOLD,
                // so wr_en never overlaps buf_ready.
                ST_CAPTURE: begin
                    if (r_last) begin
                        r_state     <= ST_HOLD;
                        r_buf_ready <= 1'b1;
                    end else if (data_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt;
                        r_wr_data <= data;
                        r_cnt     <= r_cnt + ADDR_W'(1);
                        r_last    <= (r_cnt == LAST_ADDR);
                    end
                end
                ST_HOLD: begin
                    if (frame_done) begin
                        r_buf_ready <= 1'b0;
                        r_to        <= '0;
                        r_state     <= (mode == MODE_SINGLE) ? ST_IDLE : ST_ARMED;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign buf_ready = r_buf_ready;
    assign triggered = r_triggered;
    assign state     = r_state;

endmodule

// File: tb/tb_scope_trigger_ctrl.sv
// Directed scoreboard bench for scope_trigger_ctrl: expected buffer writes are
// queued by the stimulus and checked by an independent write monitor.
module tb_scope_trigger_ctrl;

    localparam int DW    = 14;
    localparam int DEPTH = 800;
    localparam int AW    = 10;
    localparam int TO    = 2000;

    typedef struct {
        int a;
        int d;
    } exp_t;

    logic          clock;
    logic          reset;
    logic [DW-1:0] data;
    logic          data_valid;
    logic [DW-1:0] trig_level;
    logic          trig_slope;
    logic [1:0]    mode;
    logic          arm;
    logic          frame_done;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          buf_ready;
    logic          triggered;
    logic [1:0]    state;

    exp_t q[$];
    int   tests   = 0;
    int   fails   = 0;
    int   n_writes = 0;
    int   base;

    scope_trigger_ctrl #(
        .DATA_W       (DW),
        .DEPTH        (DEPTH),
        .ADDR_W       (AW),
        .AUTO_TIMEOUT (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data       (data),
        .data_valid (data_valid),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .mode       (mode),
        .arm        (arm),
        .frame_done (frame_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .buf_ready  (buf_ready),
        .triggered  (triggered),
        .state      (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Write monitor: every observed write must match the head of the queue.
    always @(negedge clock) begin
        if (!reset && wr_en) begin
            exp_t e;
            n_writes++;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", wr_addr, wr_data);
            end else begin
                e = q.pop_front();
                if (int'(wr_addr) != e.a || int'(wr_data) != e.d) begin
                    fails++;
                    $display("FAIL write_data: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             wr_addr, wr_data, e.a, e.d);
                end
            end
            tests++;
            if (state != 2'd2) begin
                fails++;
                $display("FAIL wr_en_state: got state=%0d during write, expected 2", state);
            end
        end
    end

    function automatic int pat(input int a);
        return (a * 37 + 5) & 16'h3fff;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic v);
        data       = DW'(d);
        data_valid = v;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int a, input int d);
        exp_t e;
        e.a = a;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        drive(0, 1'b0);
        frame_done = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        drive(0, 1'b0);
        arm = 1'b0;
    endtask

    task automatic capture_rest(input int start, input bit toggle);
        for (int a = start; a < DEPTH; a++) begin
            push(a, pat(a));
            drive(pat(a), 1'b1);
            if (toggle) drive(0, 1'b0);
        end
        drive(0, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        data       = '0;
        data_valid = 1'b0;
        trig_level = DW'(8000);
        trig_slope = 1'b0;
        mode       = 2'd1;
        arm        = 1'b0;
        frame_done = 1'b0;
        drive(0, 1'b0);
        drive(0, 1'b0);
        check("rst_state", state, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_buf_ready", buf_ready, 0);
        check("rst_triggered", triggered, 0);
        reset = 1'b0;

        // Normal mode, rising ramp through 8000
        drive(0, 1'b0);
        check("norm_armed", state, 1);
        for (int v = 7990; v < 8000; v++) drive(v, 1'b1);
        check("norm_no_early_trig", state, 1);
        base = n_writes;
        push(0, 8000);
        drive(8000, 1'b1);
        check("norm_capture", state, 2);
        check("norm_triggered", triggered, 1);
        for (int a = 1; a <= 10; a++) begin
            push(a, 8000 + a);
            drive(8000 + a, 1'b1);
        end
        capture_rest(11, 1'b0);
        check("norm_hold", state, 3);
        check("norm_buf_ready", buf_ready, 1);
        check("norm_write_count", n_writes - base, DEPTH);
        drive(0, 1'b0);
        drive(0, 1'b0);
        check("norm_hold_stays", state, 3);

        // Falling slope at 500, gapped data_valid during capture
        trig_slope = 1'b1;
        trig_level = DW'(500);
        pulse_fd();
        check("fall_rearm", state, 1);
        check("fall_buf_ready_clr", buf_ready, 0);
        drive(500, 1'b1);
        check("fall_first_sample_no_trig", state, 1);
        drive(600, 1'b1);
        base = n_writes;
        push(0, 500);
        drive(500, 1'b1);
        check("fall_capture", state, 2);
        check("fall_triggered", triggered, 1);
        capture_rest(1, 1'b1);
        check("fall_hold", state, 3);
        check("fall_write_count", n_writes - base, DEPTH);

        // Auto mode timeout on constant data
        mode       = 2'd0;
        trig_slope = 1'b0;
        trig_level = DW'(8000);
        pulse_fd();
        for (int i = 1; i < TO; i++) begin
            if (i % 250 == 0) drive(0, 1'b0);
            drive(100, 1'b1);
        end
        check("auto_before_timeout", state, 1);
        push(0, 100);
        drive(100, 1'b1);
        check("auto_capture", state, 2);
        check("auto_triggered", triggered, 0);
        capture_rest(1, 1'b0);
        check("auto_hold", state, 3);

        // Real trigger on the timeout sample wins
        pulse_fd();
        for (int i = 1; i < TO; i++) drive(100, 1'b1);
        check("prio_before", state, 1);
        push(0, 9000);
        drive(9000, 1'b1);
        check("prio_capture", state, 2);
        check("prio_triggered", triggered, 1);
        capture_rest(1, 1'b0);
        check("prio_hold", state, 3);

        // Single mode
        mode = 2'd2;
        pulse_fd();
        check("single_idle", state, 0);
        base = n_writes;
        for (int i = 0; i < 5000; i++) drive((i % 2) ? 9000 : 100, 1'b1);
        pulse_fd();
        check("single_stays_idle", state, 0);
        check("single_no_writes", n_writes - base, 0);
        pulse_arm();
        check("single_armed", state, 1);
        for (int i = 0; i < 2500; i++) drive(100, 1'b1);
        check("single_no_timeout", state, 1);
        push(0, 8000);
        drive(8000, 1'b1);
        check("single_capture", state, 2);
        capture_rest(1, 1'b0);
        check("single_hold", state, 3);
        pulse_arm();
        check("single_arm_ignored", state, 3);
        pulse_fd();
        check("single_back_idle", state, 0);
        check("single_buf_ready_clr", buf_ready, 0);
        for (int i = 0; i < 20; i++) drive(0, 1'b0);
        check("single_no_rearm", state, 0);

        // Reset mid-capture
        mode = 2'd1;
        drive(0, 1'b0);
        check("abort_armed", state, 1);
        drive(7000, 1'b1);
        push(0, 9000);
        drive(9000, 1'b1);
        for (int a = 1; a <= 400; a++) begin
            if (a < 400) push(a, pat(a));
            drive(pat(a), 1'b1);
        end
        check("abort_addr400", wr_addr, 400);
        check("abort_wr_en", wr_en, 1);
        reset = 1'b1;
        #1;
        check("abort_state", state, 0);
        check("abort_wr_en_clr", wr_en, 0);
        check("abort_wr_addr_clr", wr_addr, 0);
        check("abort_wr_data_clr", wr_data, 0);
        check("abort_buf_ready", buf_ready, 0);
        check("abort_triggered", triggered, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(0, 1'b0);
        check("post_reset_armed", state, 1);
        pulse_fd();
        check("fd_in_armed_ignored", state, 1);

        drive(0, 1'b0);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
